divide_low_area: RTL and testbench

//  Sequential restoring divider, the inverse of the low-area shift-add multiplier.

---
 rtl/divide_low_area_if.sv | 38 +++
 rtl/divide_low_area.sv | 142 ++++++++++++++
 tb/tb_divide_low_area.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/divide_low_area_if.sv
// Start/done handshake and operand/result bus for the low-area restoring divider.
// Same handshake as the shift-add multiplier, so both units can share a datapath slot.
interface divide_low_area_if #(
  parameter int unsigned W = 8
) ();

  logic             start;
  logic [2*W-1:0]   dividend;
  logic [W-1:0]     divisor;
  logic [2*W-1:0]   quotient;
  logic [W-1:0]     remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  quotient,
    input  remainder,
    input  done,
    input  busy,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output quotient,
    output remainder,
    output done,
    output busy,
    output div_by_zero
  );

endinterface

// File: rtl/divide_low_area.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor.
// Retires one quotient bit per clock through a single W+1-bit subtractor.
module divide_low_area #(
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             reset,
  divide_low_area_if.slave bus
);

  localparam int unsigned QW = 2 * W;
  localparam int unsigned CW = $clog2(QW);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ZERO,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [QW-1:0]   q_q, q_d;
  logic [W-1:0]    r_q, r_d;
  logic [W-1:0]    d_q, d_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [QW-1:0]   quot_q, quot_d;
  logic [W-1:0]    rem_q, rem_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            dbz_q, dbz_d;

  logic [W:0]      p;
  logic            ge;
  logic [W-1:0]    r_step;
  logic [QW-1:0]   q_step;

  // One restoring step; the remainder's top bit is always zero after a step, so only W bits are kept.
  always_comb begin
    p      = {r_q, q_q[QW-1]};
    ge     = (p >= {1'b0, d_q});
    r_step = ge ? W'(p - {1'b0, d_q}) : W'(p);
    q_step = {q_q[QW-2:0], ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    done_d  = done_q;
    busy_d  = busy_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          q_d    = bus.dividend;
          r_d    = '0;
          d_d    = bus.divisor;
          cnt_d  = CW'(QW - 1);
          done_d = 1'b0;
          dbz_d  = 1'b0;
          if (bus.divisor != '0) begin
            state_d = CALC;
            busy_d  = 1'b1;
          end else begin
            state_d = ZERO;
          end
        end
      end

      CALC: begin
        q_d   = q_step;
        r_d   = r_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          quot_d  = q_step;
          rem_d   = r_step;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end

      // Divide by zero: all-ones quotient, remainder is the low half of the captured dividend.
      ZERO: begin
        state_d = DONE;
        quot_d  = '1;
        rem_d   = q_q[W-1:0];
        dbz_d   = 1'b1;
        done_d  = 1'b1;
      end

      // A level-held start must drop before another division can be accepted.
      DONE: begin
        if (!bus.start) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divide_low_area.sv
// Self-checking bench for divide_low_area: directed vectors, reset/handshake corners,
// and a randomized sweep against a plain-arithmetic reference.
module tb_divide_low_area;

  localparam int unsigned W  = 8;
  localparam int unsigned QW = 2 * W;

  logic clk;
  logic reset;

  divide_low_area_if #(.W(W)) bus ();

  divide_low_area #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  task automatic ref_div(input logic [QW-1:0] a, input logic [W-1:0] b,
                         output logic [QW-1:0] q, output logic [W-1:0] r, output logic z);
    int unsigned ai, bi;
    ai = 32'(a);
    bi = 32'(b);
    if (bi == 0) begin
      q = '1;
      r = a[W-1:0];
      z = 1'b1;
    end else begin
      q = QW'(ai / bi);
      r = W'(ai % bi);
      z = 1'b0;
    end
  endtask

  // One idle cycle, a single-cycle start pulse, then wait (bounded) for done.
  // Operands are scrambled right after acceptance to show they are captured.
  task automatic run_op(input logic [QW-1:0] a, input logic [W-1:0] b,
                        output logic [QW-1:0] q, output logic [W-1:0] r, output logic z,
                        output int lat, output logic busy_seen, output logic done_e0);
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = QW'($urandom);
    bus.divisor  = W'($urandom);
    done_e0   = bus.done;
    busy_seen = bus.busy;
    lat       = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_seen = 1'b1;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
  endtask

  typedef struct {
    logic [QW-1:0] dvd;
    logic [W-1:0]  dvs;
    logic [QW-1:0] q;
    logic [W-1:0]  r;
    logic          z;
    int            lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [QW-1:0] q, eq;
    logic [W-1:0]  r, er;
    logic          z, ez, bs, d0;
    logic          prev_done;
    int            lat, done_rises, busy_rises;
    logic          prev_busy;
    logic [QW-1:0] ra;
    logic [W-1:0]  rb;

    vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,    1'b0, 16};
    vecs[1] = '{16'd65535, 8'd255, 16'd257,   8'd0,    1'b0, 16};
    vecs[2] = '{16'd65535, 8'd1,   16'd65535, 8'd0,    1'b0, 16};
    vecs[3] = '{16'd100,   8'd200, 16'd0,     8'd100,  1'b0, 16};
    vecs[4] = '{16'd0,     8'd9,   16'd0,     8'd0,    1'b0, 16};
    vecs[5] = '{16'd1234,  8'd0,   16'hFFFF,  8'hD2,   1'b1, 1};
    vecs[6] = '{16'd255,   8'd255, 16'd1,     8'd0,    1'b0, 16};
    vecs[7] = '{16'd65535, 8'd254, 16'd258,   8'd3,    1'b0, 16};

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #3;
    check("reset_quotient", bus.quotient, 0);
    check("reset_remainder", bus.remainder, 0);
    check("reset_done", bus.done, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_dbz", bus.div_by_zero, 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].dvd, vecs[i].dvs, q, r, z, lat, bs, d0);
      check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
      check($sformatf("vec%0d_remainder", i), r, vecs[i].r);
      check($sformatf("vec%0d_dbz", i), z, vecs[i].z);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy_seen", i), bs, (vecs[i].dvs != 0) ? 1 : 0);
      check($sformatf("vec%0d_done_cleared_e0", i), d0, 0);
      check($sformatf("vec%0d_busy_at_done", i), bus.busy, 0);
    end

    // Asynchronous reset mid-clock, five cycles into CALC
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midreset_quotient", bus.quotient, 0);
    check("midreset_remainder", bus.remainder, 0);
    check("midreset_done", bus.done, 0);
    check("midreset_busy", bus.busy, 0);
    check("midreset_dbz", bus.div_by_zero, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle_busy", bus.busy, 0);
    run_op(16'd1000, 8'd7, q, r, z, lat, bs, d0);
    check("post_reset_quotient", q, 142);
    check("post_reset_remainder", r, 6);
    check("post_reset_latency", lat, 16);

    // Level-held start for 40 cycles; operands changed mid-CALC
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    prev_done  = bus.done;
    prev_busy  = bus.busy;
    done_rises = 0;
    busy_rises = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (c == 3) begin
        bus.dividend = 16'd50;
        bus.divisor  = 8'd3;
      end
      if (bus.done && !prev_done) done_rises++;
      if (bus.busy && !prev_busy) busy_rises++;
      prev_done = bus.done;
      prev_busy = bus.busy;
    end
    check("held_done_rises", done_rises, 1);
    check("held_busy_rises", busy_rises, 1);
    check("held_done_level", bus.done, 1);
    check("held_quotient", bus.quotient, 142);
    check("held_remainder", bus.remainder, 6);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("held_release_done_kept", bus.done, 1);
    check("held_release_quotient_kept", bus.quotient, 142);
    run_op(16'd50, 8'd3, q, r, z, lat, bs, d0);
    check("second_req_quotient", q, 16);
    check("second_req_remainder", r, 2);

    // start held high through reset release: first edge afterwards accepts
    @(posedge clk); #1;
    reset        = 1'b1;
    bus.dividend = 16'd100;
    bus.divisor  = 8'd200;
    bus.start    = 1'b1;
    #12;
    check("rst_start_done_low", bus.done, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("rst_start_busy", bus.busy, 1);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    check("rst_start_latency", lat, 16);
    check("rst_start_quotient", bus.quotient, 0);
    check("rst_start_remainder", bus.remainder, 100);

    // Random sweep against the reference model
    for (int k = 0; k < 2000; k++) begin
      ra = QW'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? W'(0) : W'($urandom);
      ref_div(ra, rb, eq, er, ez);
      run_op(ra, rb, q, r, z, lat, bs, d0);
      check($sformatf("rand%0d_quotient(%0d/%0d)", k, ra, rb), q, eq);
      check($sformatf("rand%0d_remainder(%0d/%0d)", k, ra, rb), r, er);
      check($sformatf("rand%0d_dbz", k), z, ez);
      check($sformatf("rand%0d_latency", k), lat, (rb == 0) ? 1 : 16);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
